// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and size-to-byte-count table for dmem_ctrl
package dmem_pkg;

  // Access size encodings on req_size; 2'd3 is illegal
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Bytes touched per size encoding, indexed by req_size (entry 3 is never used for an access)
  localparam logic [3:0][2:0] SIZE_BYTES = {3'd4, 3'd4, 3'd2, 3'd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - selects the loaded field from 4 big-endian bytes and sign/zero-extends it
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] bytes_be,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic sign_bit;

  // The addressed byte always sits in [31:24], so the field's top bit is bit 31
  always_comb begin
    sign_bit = bytes_be[31] & ~is_unsigned;
    data     = '0;
    case (size)
      SZ_BYTE: data = {{24{sign_bit}}, bytes_be[31:24]};
      SZ_HALF: data = {{16{sign_bit}}, bytes_be[31:16]};
      SZ_WORD: data = bytes_be;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-outstanding big-endian data memory controller; DMEM_MISALIGN_TRAP_EN traps misaligned accesses
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_BYTES);
  localparam int         AW1      = ADDR_W + 1;
  localparam int         CNT_INIT = (RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0;
  localparam logic [1:0] CNT_LOAD = 2'(CNT_INIT);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept;
  logic [ADDR_W-1:0] addr_eff;
  logic [ADDR_W:0]   last_byte;
  logic              req_err;
  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  idx1;
  logic [IDX_W-1:0]  idx2;
  logic [IDX_W-1:0]  idx3;

  logic [31:0]       stage_bytes;
  logic [1:0]        stage_size;
  logic              stage_unsigned;
  logic              stage_write;
  logic              stage_err;
  logic [31:0]       lane_data;

  assign accept = req_valid && req_ready;

  // Address decode and error classification for the request currently on the bus
  always_comb begin
    addr_eff  = req_addr;
    // Range is judged on the address as issued, before any low-bit forcing
    last_byte = {1'b0, req_addr} + AW1'(SIZE_BYTES[req_size]) - AW1'(1);
    req_err   = (req_size == 2'd3) || (last_byte >= AW1'(DEPTH_BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((req_size == SZ_HALF && req_addr[0]) ||
        (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`else
    if (req_size == SZ_HALF) addr_eff[0]   = 1'b0;
    if (req_size == SZ_WORD) addr_eff[1:0] = 2'b00;
`endif
    idx0 = addr_eff[IDX_W-1:0];
    idx1 = idx0 + IDX_W'(1);
    idx2 = idx0 + IDX_W'(2);
    idx3 = idx0 + IDX_W'(3);
  end

  // Byte array: stores commit on the acceptance edge; contents are never reset
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      case (req_size)
        SZ_BYTE: mem[idx0] <= req_wdata[7:0];
        SZ_HALF: begin
          mem[idx0] <= req_wdata[15:8];
          mem[idx1] <= req_wdata[7:0];
        end
        SZ_WORD: begin
          mem[idx0] <= req_wdata[31:24];
          mem[idx1] <= req_wdata[23:16];
          mem[idx2] <= req_wdata[15:8];
          mem[idx3] <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Capture the addressed bytes and request attributes so the response holds steady
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_bytes    <= '0;
      stage_size     <= SZ_BYTE;
      stage_unsigned <= 1'b0;
      stage_write    <= 1'b0;
      stage_err      <= 1'b0;
    end else if (accept) begin
      stage_bytes    <= {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
      stage_size     <= req_size;
      stage_unsigned <= req_unsigned;
      stage_write    <= req_write;
      stage_err      <= req_err;
    end
  end

  // Latency counter: loaded on acceptance, counts down while waiting in BUSY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == BUSY && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (RD_LATENCY == 1) ? RESP : BUSY;
      end
      BUSY: begin
        if (cnt == 2'd0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  dmem_lane u_lane (
    .bytes_be    (stage_bytes),
    .size        (stage_size),
    .is_unsigned (stage_unsigned),
    .data        (lane_data)
  );

  assign resp_err   = resp_valid && stage_err;
  assign resp_rdata = (resp_valid && !stage_write && !stage_err) ? lane_data : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl at read latency 1 and 3
module tb_dmem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;

  logic        a_req_valid, a_req_ready, a_req_write, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_BYTES(1024), .ADDR_W(32), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .reset_n(rst_a_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_ctrl #(.DEPTH_BYTES(1024), .ADDR_W(32), .RD_LATENCY(3)) u_dut_b (
    .clk(clk), .reset_n(rst_b_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, req);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
  task automatic issue_a(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input string nm);
    exp_t e;
    int   t = 0;
    e.rdata = exp_d; e.err = exp_e; e.name = nm;
    exp_a.push_back(e);
    @(posedge clk); #1;
    while (!a_req_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk1({nm, "_req_ready_wait"}, (t < 50), 1'b1);
    a_req_valid = 1'b1; a_req_write = w; a_req_size = sz; a_req_unsigned = u;
    a_req_addr = ad; a_req_wdata = wd;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = 32'hA5A5_A5A5;
  endtask

  task automatic issue_b(input logic w, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [31:0] wd, input logic push,
                         input logic [31:0] exp_d, input logic exp_e, input string nm);
    exp_t e;
    int   t = 0;
    if (push) begin
      e.rdata = exp_d; e.err = exp_e; e.name = nm;
      exp_b.push_back(e);
    end
    @(posedge clk); #1;
    while (!b_req_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk1({nm, "_req_ready_wait"}, (t < 50), 1'b1);
    b_req_valid = 1'b1; b_req_write = w; b_req_size = sz; b_req_unsigned = 1'b0;
    b_req_addr = ad; b_req_wdata = wd;
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_req_addr = 32'h0000_0000; b_req_wdata = 32'h5A5A_5A5A;
  endtask

  // Scoreboard monitor for instance A: every completed handshake pops one expectation
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_resp_valid && a_resp_ready) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_resp actual=%0h required=none", a_resp_rdata);
      end else begin
        e = exp_a.pop_front();
        chk({e.name, "_rdata"}, a_resp_rdata, e.rdata);
        chk1({e.name, "_err"}, a_resp_err, e.err);
      end
    end
  end

  // Scoreboard monitor for instance B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_resp_valid && b_resp_ready) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_resp actual=%0h required=none", b_resp_rdata);
      end else begin
        e = exp_b.pop_front();
        chk({e.name, "_rdata"}, b_resp_rdata, e.rdata);
        chk1({e.name, "_err"}, b_resp_err, e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_size = 2'd0; a_req_unsigned = 1'b0;
    a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
    b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk1("a_rst_req_ready", a_req_ready, 1'b1);
    chk1("a_rst_resp_valid", a_resp_valid, 1'b0);
    chk("a_rst_resp_rdata", a_resp_rdata, 32'h0);
    chk1("a_rst_resp_err", a_resp_err, 1'b0);
    chk1("b_rst_req_ready", b_req_ready, 1'b1);
    chk1("b_rst_resp_valid", b_resp_valid, 1'b0);
    @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Store then signed/unsigned loads, latency 1
    issue_a(1, 2'd2, 0, 32'h10, 32'h8899AABB, 32'h0, 0, "sw_10");
    issue_a(0, 2'd0, 0, 32'h10, 32'h0, 32'hFFFFFF88, 0, "lb_10");
    issue_a(0, 2'd0, 1, 32'h11, 32'h0, 32'h00000099, 0, "lbu_11");
    issue_a(0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFFAABB, 0, "lh_12");
    issue_a(0, 2'd1, 1, 32'h12, 32'h0, 32'h0000AABB, 0, "lhu_12");
    issue_a(0, 2'd2, 1, 32'h10, 32'h0, 32'h8899AABB, 0, "lw_unsigned_ignored");
`ifdef DMEM_MISALIGN_TRAP_EN
    issue_a(0, 2'd2, 0, 32'h13, 32'h0, 32'h0, 1, "lw_misaligned_13");
`else
    issue_a(0, 2'd2, 0, 32'h13, 32'h0, 32'h8899AABB, 0, "lw_misaligned_13");
`endif

    // Partial stores
    issue_a(1, 2'd1, 0, 32'h10, 32'h00001234, 32'h0, 0, "sh_10");
    issue_a(0, 2'd2, 0, 32'h10, 32'h0, 32'h1234AABB, 0, "lw_after_sh");
    issue_a(1, 2'd0, 0, 32'h13, 32'h0000007F, 32'h0, 0, "sb_13");
    issue_a(0, 2'd2, 0, 32'h10, 32'h0, 32'h1234AA7F, 0, "lw_after_sb");

    // Range errors, illegal size, last-byte boundary
    issue_a(1, 2'd2, 0, 32'h0, 32'h01020304, 32'h0, 0, "sw_0");
    issue_a(1, 2'd2, 0, 32'h400, 32'hFFFFFFFF, 32'h0, 1, "sw_400_oob");
    issue_a(0, 2'd2, 0, 32'h0, 32'h0, 32'h01020304, 0, "lw_0_unchanged");
    issue_a(0, 2'd2, 0, 32'h3FE, 32'h0, 32'h0, 1, "lw_3fe_oob");
    issue_a(0, 2'd3, 0, 32'h8, 32'h0, 32'h0, 1, "size3");
    issue_a(1, 2'd0, 0, 32'h3FF, 32'h00000080, 32'h0, 0, "sb_3ff");
    issue_a(0, 2'd0, 0, 32'h3FF, 32'h0, 32'hFFFFFF80, 0, "lb_3ff");

    // Latency 3: count edges from the acceptance edge (inclusive) to resp_valid
    issue_b(1, 2'd2, 32'h30, 32'h55667788, 1, 32'h0, 0, "b_sw_30");
    @(negedge clk);
    n = 1;
    while (!b_resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("b_latency_edges", 32'(n), 32'd3);

    // Backpressure: hold resp_ready low for 4 cycles
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
    issue_b(0, 2'd2, 32'h30, 32'h0, 1, 32'h55667788, 0, "b_lw_30");
    t = 0;
    @(negedge clk);
    while (!b_resp_valid && t < 20) begin @(negedge clk); t++; end
    chk1("b_bp_valid_seen", (t < 20), 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("b_bp_resp_valid", b_resp_valid, 1'b1);
      chk("b_bp_resp_rdata", b_resp_rdata, 32'h55667788);
      chk1("b_bp_req_ready", b_req_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    b_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("b_post_hs_req_ready", b_req_ready, 1'b1);
    chk1("b_post_hs_resp_valid", b_resp_valid, 1'b0);

    // Reset while BUSY: response dropped, store stays committed
    issue_b(1, 2'd2, 32'h20, 32'hDEADBEEF, 0, 32'h0, 0, "b_sw_20");
    @(posedge clk); #1;
    rst_b_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk1("b_midrst_req_ready", b_req_ready, 1'b1);
      chk1("b_midrst_resp_valid", b_resp_valid, 1'b0);
    end
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("b_after_rst_no_resp", b_resp_valid, 1'b0);
    end
    issue_b(0, 2'd2, 32'h20, 32'h0, 1, 32'hDEADBEEF, 0, "b_lw_20");

    // Drain both scoreboards
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 100) begin
      @(negedge clk); t++;
    end
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
